// File: rtl/result_serializer_pkg.sv
// Shared constants and types for the result serializer.
// Holds the word width, the bytes-per-word count, the byte index type and the
// serializer FSM state encoding used by result_serializer and result_fifo.
package result_serializer_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } ser_state_e;

    typedef logic [IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/result_fifo.sv
// Power-of-two circular FIFO holding whole result words.
// Ports:
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   push, push_data  write request and word; ignored while full
//   pop, pop_data    read request and head word (pop_data valid when !empty)
//   count            number of stored words (0..DEPTH)
//   full, empty      occupancy flags
// Storage contents are not reset; only pointers and count are.
module result_fifo
    import result_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/result_serializer.sv
// Buffers 32-bit multiplier results and emits them as MSB-first bytes over a
// valid/ready byte stream.
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid, in_data     result word offered by the right-shift stage
//   in_ready              FIFO has room (count != DEPTH)
//   out_valid, out_byte   current byte of the word being sent
//   out_last              high on the fourth byte of a word
//   out_ready             consumer accepts the byte
//   out_parity            even-parity bit of out_byte, 0 unless
//                         RESULT_SER_PARITY_EN is defined
//   count                 words held in the FIFO (not counting the one being sent)
//   overflow              sticky: a word was offered while in_ready was low
// Configuration macro: RESULT_SER_PARITY_EN enables the parity generator.
module result_serializer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = result_serializer_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_byte,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   out_parity,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    import result_serializer_pkg::*;

    ser_state_e        state_q, state_d;
    byte_idx_t         idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The byte on the wire is always the top byte of the shift register, so
    // out_byte/out_last/out_valid are pure functions of registered state and
    // hold still under backpressure without extra logic.
    assign out_valid = (state_q == StSend);
    assign out_byte  = shreg_q[DATA_W-1 -: BYTE_W];
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign overflow  = overflow_q;

`ifdef RESULT_SER_PARITY_EN
    assign out_parity = ^out_byte;
`else
    assign out_parity = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (in_valid & ~in_ready);

        // fifo_empty reflects the count before this cycle's push, so a word
        // pushed this cycle is only poppable from the next one.
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        if (!fifo_empty) begin
                            // Chain straight into the next word: no idle bubble.
                            pop     = 1'b1;
                            shreg_d = fifo_head;
                            idx_d   = '0;
                        end else begin
                            shreg_d = '0;
                            idx_d   = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        shreg_d = shreg_q << BYTE_W;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            shreg_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_result_serializer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef RESULT_SER_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_byte;
    logic             out_last;
    logic             out_ready;
    logic             out_parity;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    result_serializer #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .count      (count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
        return 8'(w >> (24 - 8 * idx));
    endfunction

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (count !== CNT_W'(0)) begin errors++;
            $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++;
            $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (out_byte !== 8'h00) begin errors++;
            $display("FAIL reset_out_byte got %h want 00", out_byte); end
        checks++; if (out_last !== 1'b0) begin errors++;
            $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (out_parity !== 1'b0) begin errors++;
            $display("FAIL reset_out_parity got %b want 0", out_parity); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    // Push 0x12345678 into an idle block; bytes 12,34,56,78 on consecutive cycles.
    task automatic test_single_word();
        logic [31:0] w;
        w = 32'h12345678;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = w;
        tick();                                   // push edge
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL single_latency out_valid got %b want 0", out_valid); end
        checks++; if (count !== CNT_W'(1)) begin errors++;
            $display("FAIL single_count got %0d want 1", count); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++;
                $display("FAIL single_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_byte !== byte_of(w, i)) begin errors++;
                $display("FAIL single_byte[%0d] got %h want %h", i, out_byte, byte_of(w, i)); end
            checks++; if (out_last !== (i == 3)) begin errors++;
                $display("FAIL single_last[%0d] got %b want %b", i, out_last, (i == 3)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL single_done out_valid got %b want 0", out_valid); end
    endtask

    // Two words pushed back-to-back stream as 8 contiguous bytes.
    task automatic test_back_to_back();
        logic [31:0] w [2];
        logic [7:0]  exp_b;
        w[0] = 32'hA0B0C0D0;
        w[1] = 32'h01020304;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = w[k];
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_b = byte_of(w[i / 4], i % 4);
            checks++; if (out_valid !== 1'b1) begin errors++;
                $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_byte !== exp_b) begin errors++;
                $display("FAIL b2b_byte[%0d] got %h want %h", i, out_byte, exp_b); end
            checks++; if (out_last !== (i % 4 == 3)) begin errors++;
                $display("FAIL b2b_last[%0d] got %b want %b", i, out_last, (i % 4 == 3)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_done out_valid got %b want 0", out_valid); end
    endtask

    // Stall the consumer for 5 cycles while byte 0x34 is on the wire.
    task automatic test_backpressure();
        logic [31:0] w;
        w = 32'h12345678;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = w;
        tick();
        in_valid = 1'b0;
        tick();                                   // 0x12 on the wire
        tick();                                   // 0x34 on the wire
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_byte !== 8'h34 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] got v=%b b=%h l=%b want v=1 b=34 l=0",
                         i, out_valid, out_byte, out_last);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++; if (out_byte !== 8'h34) begin errors++;
            $display("FAIL stall_release got %h want 34", out_byte); end
        tick();
        checks++; if (out_byte !== 8'h56) begin errors++;
            $display("FAIL stall_next got %h want 56", out_byte); end
        tick();
        checks++; if (out_byte !== 8'h78 || out_last !== 1'b1) begin errors++;
            $display("FAIL stall_last got b=%h l=%b want b=78 l=1", out_byte, out_last); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL stall_done out_valid got %b want 0", out_valid); end
    endtask

    // Six pushes with the consumer stalled: five fit, the sixth is dropped.
    task automatic test_overflow();
        logic [31:0] w [6];
        logic [7:0]  exp_b;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w[i]     = $urandom();
            in_valid = 1'b1;
            in_data  = w[i];
            tick();
            if (i == 4) begin
                checks++; if (count !== CNT_W'(4) || overflow !== 1'b0) begin errors++;
                    $display("FAIL ovf_fifth got cnt=%0d ovf=%b want cnt=4 ovf=0",
                             count, overflow);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (count !== CNT_W'(DEPTH)) begin errors++;
            $display("FAIL ovf_count got %0d want %0d", count, DEPTH); end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL ovf_in_ready got %b want 0", in_ready); end
        checks++; if (overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_flag got %b want 1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_b = byte_of(w[i / 4], i % 4);
            checks++; if (out_valid !== 1'b1 || out_byte !== exp_b) begin errors++;
                $display("FAIL ovf_drain[%0d] got v=%b b=%h want v=1 b=%h",
                         i, out_valid, out_byte, exp_b);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || count !== CNT_W'(0)) begin errors++;
            $display("FAIL ovf_empty got v=%b cnt=%0d want v=0 cnt=0", out_valid, count); end
        checks++; if (overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    // Reset during byte 2 of a word abandons it; overflow (set earlier) clears.
    task automatic test_reset_mid_word();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hCAFEBABE;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();                                   // byte index 2 (0xBA) on the wire
        checks++; if (out_byte !== 8'hBA) begin errors++;
            $display("FAIL rstmid_pre got %h want BA", out_byte); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || count !== CNT_W'(0) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear got v=%b cnt=%0d ovf=%b want 0 0 0",
                     out_valid, count, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("FAIL rstmid_idle[%0d] got %b want 0", i, out_valid); end
        end
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_byte !== 8'hFF || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL rstmid_ff[%0d] got v=%b b=%h l=%b want v=1 b=ff l=%b",
                         i, out_valid, out_byte, out_last, (i == 3));
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_done got %b want 0", out_valid); end
    endtask

    // Bytes 07,03,FF,01 give parity 1,0,0,1 when enabled, all 0 otherwise.
    task automatic test_parity();
        logic [31:0] w;
        logic [3:0]  ptab;
        w    = 32'h0703FF01;
        ptab = PAR_ON ? 4'b1001 : 4'b0000;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = w;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_byte !== byte_of(w, i) || out_parity !== ptab[3 - i]) begin
                errors++;
                $display("FAIL parity[%0d] got b=%h p=%b want b=%h p=%b",
                         i, out_byte, out_parity, byte_of(w, i), ptab[3 - i]);
            end
            tick();
        end
    endtask

    // Random traffic against a model: a queue of stored words plus the word
    // currently being transmitted and its byte position.
    task automatic test_random();
        logic [31:0] m_q[$];
        bit          m_busy;
        logic [31:0] m_word;
        int          m_idx;
        bit          m_ovf;
        int          m_size;
        bit          accept;
        logic [7:0]  exp_b;
        do_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_word = '0;
        m_idx  = 0;
        m_ovf  = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 9) < 6);
            m_size = m_q.size();
            accept = in_valid && (m_size != DEPTH);
            if (in_valid && !accept) m_ovf = 1'b1;
            if (!m_busy) begin
                if (m_size > 0) begin
                    m_word = m_q.pop_front();
                    m_busy = 1'b1;
                    m_idx  = 0;
                end
            end else if (out_ready) begin
                if (m_idx == 3) begin
                    if (m_size > 0) begin
                        m_word = m_q.pop_front();
                        m_idx  = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    m_idx++;
                end
            end
            if (accept) m_q.push_back(in_data);
            tick();
            exp_b = byte_of(m_word, m_idx);
            checks++; if (out_valid !== m_busy) begin errors++;
                $display("FAIL rand_valid@%0d got %b want %b", cyc, out_valid, m_busy); end
            checks++; if (out_last !== (m_busy && m_idx == 3)) begin errors++;
                $display("FAIL rand_last@%0d got %b want %b", cyc, out_last,
                         (m_busy && m_idx == 3)); end
            checks++; if (count !== CNT_W'(m_q.size())) begin errors++;
                $display("FAIL rand_count@%0d got %0d want %0d", cyc, count, m_q.size()); end
            checks++; if (in_ready !== (m_q.size() != DEPTH)) begin errors++;
                $display("FAIL rand_in_ready@%0d got %b want %b", cyc, in_ready,
                         (m_q.size() != DEPTH)); end
            checks++; if (overflow !== m_ovf) begin errors++;
                $display("FAIL rand_overflow@%0d got %b want %b", cyc, overflow, m_ovf); end
            if (m_busy) begin
                checks++; if (out_byte !== exp_b) begin errors++;
                    $display("FAIL rand_byte@%0d got %h want %h", cyc, out_byte, exp_b); end
                checks++; if (out_parity !== (PAR_ON & (^exp_b))) begin errors++;
                    $display("FAIL rand_parity@%0d got %b want %b", cyc, out_parity,
                             (PAR_ON & (^exp_b))); end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_word();
        test_parity();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
